// File: rtl/inorder_rs_entry_array.sv
// In-order reservation-station entry array.
// Holds dispatched instructions written at the allocation pointer. Captures
// operands from the CDB, both at dispatch time and while an entry waits.
// Publishes busy/ready vectors and issues the entry at the issue pointer
// through a registered port.
module inorder_rs_entry_array #(
  parameter int ENT_SEL = 2,
  parameter int ENT_NUM = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int CTRL_W  = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [1:0]          dp_num_i,
  input  logic                dp_stall_i,
  input  logic                dp_kill_i,
  input  logic [ENT_SEL-1:0]  alloc_ptr_i,
  input  logic [DATA_W-1:0]   dp0_src1_i,
  input  logic [DATA_W-1:0]   dp0_src2_i,
  input  logic                dp0_src1_rdy_i,
  input  logic                dp0_src2_rdy_i,
  input  logic [CTRL_W-1:0]   dp0_ctrl_i,
  input  logic [DATA_W-1:0]   dp1_src1_i,
  input  logic [DATA_W-1:0]   dp1_src2_i,
  input  logic                dp1_src1_rdy_i,
  input  logic                dp1_src2_rdy_i,
  input  logic [CTRL_W-1:0]   dp1_ctrl_i,
  input  logic                cdb_valid_i,
  input  logic [TAG_W-1:0]    cdb_tag_i,
  input  logic [DATA_W-1:0]   cdb_data_i,
  input  logic [ENT_SEL-1:0]  issue_ptr_i,
  input  logic                issue_en_i,
  output logic [ENT_NUM-1:0]  busy_vector_o,
  output logic [ENT_NUM-1:0]  busy_vector_next_o,
  output logic [ENT_NUM-1:0]  ready_vector_o,
  output logic                iss_valid_o,
  output logic [DATA_W-1:0]   iss_src1_o,
  output logic [DATA_W-1:0]   iss_src2_o,
  output logic [CTRL_W-1:0]   iss_ctrl_o
);

  // An unready operand matches a valid broadcast carrying its tag.
  function automatic logic tag_hit(input logic rdy, input logic [TAG_W-1:0] opnd_tag,
                                   input logic cv, input logic [TAG_W-1:0] ctag);
    return ~rdy & cv & (opnd_tag == ctag);
  endfunction

  // Entry storage
  logic [ENT_NUM-1:0] busy_r, rdy1_r, rdy2_r;
  logic [DATA_W-1:0]  src1_r [ENT_NUM];
  logic [DATA_W-1:0]  src2_r [ENT_NUM];
  logic [CTRL_W-1:0]  ctrl_r [ENT_NUM];

  // Next-state of entry storage
  logic [ENT_NUM-1:0] rdy1_n_s, rdy2_n_s;
  logic [DATA_W-1:0]  src1_n_s [ENT_NUM];
  logic [DATA_W-1:0]  src2_n_s [ENT_NUM];
  logic [CTRL_W-1:0]  ctrl_n_s [ENT_NUM];

  // Dispatch slots after bypass resolution (index 0 = dp0, 1 = dp1)
  logic [1:0][DATA_W-1:0] dp_src1_s, dp_src2_s;
  logic [1:0]             dp_rdy1_s, dp_rdy2_s;
  logic [1:0][CTRL_W-1:0] dp_ctrl_s;

  logic                dp_we_s;
  logic [ENT_SEL-1:0]  idx0_s, idx1_s;
  logic [ENT_NUM-1:0]  set_mask_s, clr_mask_s, busy_next_s, ready_s;
  logic                issue_fire_s;

  assign dp_we_s = (dp_num_i != 2'd0) & ~dp_stall_i & ~dp_kill_i;
  assign idx0_s  = alloc_ptr_i;
  assign idx1_s  = alloc_ptr_i + ENT_SEL'(1);

  assign ready_s      = busy_r & rdy1_r & rdy2_r;
  assign issue_fire_s = issue_en_i & ready_s[issue_ptr_i] & ~dp_kill_i;

  // Dispatch-set and issue-clear masks, and the resulting next busy bits.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (dp_we_s) begin
      set_mask_s[idx0_s] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (dp_we_s && (dp_num_i == 2'd2)) begin
      set_mask_s[idx1_s] = 1'b1;
    end else begin
      set_mask_s = set_mask_s;
    end
    if (issue_fire_s) begin
      clr_mask_s[issue_ptr_i] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    if (dp_kill_i) begin
      busy_next_s = '0;
    end else begin
      busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Resolve incoming operands against a same-cycle CDB broadcast.
  always_comb begin
    dp_ctrl_s[0] = dp0_ctrl_i;
    dp_ctrl_s[1] = dp1_ctrl_i;
    if (tag_hit(dp0_src1_rdy_i, dp0_src1_i[TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
      dp_src1_s[0] = cdb_data_i;  dp_rdy1_s[0] = 1'b1;
    end else begin
      dp_src1_s[0] = dp0_src1_i;  dp_rdy1_s[0] = dp0_src1_rdy_i;
    end
    if (tag_hit(dp0_src2_rdy_i, dp0_src2_i[TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
      dp_src2_s[0] = cdb_data_i;  dp_rdy2_s[0] = 1'b1;
    end else begin
      dp_src2_s[0] = dp0_src2_i;  dp_rdy2_s[0] = dp0_src2_rdy_i;
    end
    if (tag_hit(dp1_src1_rdy_i, dp1_src1_i[TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
      dp_src1_s[1] = cdb_data_i;  dp_rdy1_s[1] = 1'b1;
    end else begin
      dp_src1_s[1] = dp1_src1_i;  dp_rdy1_s[1] = dp1_src1_rdy_i;
    end
    if (tag_hit(dp1_src2_rdy_i, dp1_src2_i[TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
      dp_src2_s[1] = cdb_data_i;  dp_rdy2_s[1] = 1'b1;
    end else begin
      dp_src2_s[1] = dp1_src2_i;  dp_rdy2_s[1] = dp1_src2_rdy_i;
    end
  end

  // Per-entry next state: a dispatch write wins, otherwise CDB wakeup on busy entries.
  always_comb begin
    rdy1_n_s = rdy1_r;
    rdy2_n_s = rdy2_r;
    for (int e = 0; e < ENT_NUM; e++) begin
      src1_n_s[e] = src1_r[e];
      src2_n_s[e] = src2_r[e];
      ctrl_n_s[e] = ctrl_r[e];
      if (set_mask_s[e] && (ENT_SEL'(e) == idx0_s)) begin
        src1_n_s[e] = dp_src1_s[0];  rdy1_n_s[e] = dp_rdy1_s[0];
        src2_n_s[e] = dp_src2_s[0];  rdy2_n_s[e] = dp_rdy2_s[0];
        ctrl_n_s[e] = dp_ctrl_s[0];
      end else if (set_mask_s[e]) begin
        src1_n_s[e] = dp_src1_s[1];  rdy1_n_s[e] = dp_rdy1_s[1];
        src2_n_s[e] = dp_src2_s[1];  rdy2_n_s[e] = dp_rdy2_s[1];
        ctrl_n_s[e] = dp_ctrl_s[1];
      end else begin
        if (busy_r[e] && !dp_kill_i &&
            tag_hit(rdy1_r[e], src1_r[e][TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
          src1_n_s[e] = cdb_data_i;  rdy1_n_s[e] = 1'b1;
        end else begin
          src1_n_s[e] = src1_r[e];   rdy1_n_s[e] = rdy1_r[e];
        end
        if (busy_r[e] && !dp_kill_i &&
            tag_hit(rdy2_r[e], src2_r[e][TAG_W-1:0], cdb_valid_i, cdb_tag_i)) begin
          src2_n_s[e] = cdb_data_i;  rdy2_n_s[e] = 1'b1;
        end else begin
          src2_n_s[e] = src2_r[e];   rdy2_n_s[e] = rdy2_r[e];
        end
      end
    end
  end

  // Entry storage registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_r <= '0;
      rdy1_r <= '0;
      rdy2_r <= '0;
      for (int e = 0; e < ENT_NUM; e++) begin
        src1_r[e] <= '0;
        src2_r[e] <= '0;
        ctrl_r[e] <= '0;
      end
    end else begin
      busy_r <= busy_next_s;
      rdy1_r <= rdy1_n_s;
      rdy2_r <= rdy2_n_s;
      for (int e = 0; e < ENT_NUM; e++) begin
        src1_r[e] <= src1_n_s[e];
        src2_r[e] <= src2_n_s[e];
        ctrl_r[e] <= ctrl_n_s[e];
      end
    end
  end

  // Registered issue port; payload holds when nothing issues.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      iss_valid_o <= 1'b0;
      iss_src1_o  <= '0;
      iss_src2_o  <= '0;
      iss_ctrl_o  <= '0;
    end else if (issue_fire_s) begin
      iss_valid_o <= 1'b1;
      iss_src1_o  <= src1_r[issue_ptr_i];
      iss_src2_o  <= src2_r[issue_ptr_i];
      iss_ctrl_o  <= ctrl_r[issue_ptr_i];
    end else begin
      iss_valid_o <= 1'b0;
    end
  end

  assign busy_vector_o      = busy_r;
  assign busy_vector_next_o = busy_next_s;
  assign ready_vector_o     = ready_s;

endmodule

// File: tb/tb_inorder_rs_entry_array.sv
// Scoreboard bench for inorder_rs_entry_array: issued payloads are predicted
// when the issue is requested and compared when iss_valid_o shows up.
module tb_inorder_rs_entry_array;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [15:0] c;
  } iss_t;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [1:0]  dp_num_i = 2'd0;
  logic        dp_stall_i = 1'b0, dp_kill_i = 1'b0;
  logic [1:0]  alloc_ptr_i = 2'd0;
  logic [31:0] dp0_src1_i = 32'd0, dp0_src2_i = 32'd0, dp1_src1_i = 32'd0, dp1_src2_i = 32'd0;
  logic        dp0_src1_rdy_i = 1'b0, dp0_src2_rdy_i = 1'b0, dp1_src1_rdy_i = 1'b0, dp1_src2_rdy_i = 1'b0;
  logic [15:0] dp0_ctrl_i = 16'd0, dp1_ctrl_i = 16'd0;
  logic        cdb_valid_i = 1'b0;
  logic [5:0]  cdb_tag_i = 6'd0;
  logic [31:0] cdb_data_i = 32'd0;
  logic [1:0]  issue_ptr_i = 2'd0;
  logic        issue_en_i = 1'b0;
  logic [3:0]  busy_vector_o, busy_vector_next_o, ready_vector_o;
  logic        iss_valid_o;
  logic [31:0] iss_src1_o, iss_src2_o;
  logic [15:0] iss_ctrl_o;

  int   errors = 0;
  int   checks = 0;
  iss_t exp_q[$];
  iss_t last_iss = '0;

  inorder_rs_entry_array dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .dp_num_i(dp_num_i), .dp_stall_i(dp_stall_i), .dp_kill_i(dp_kill_i),
    .alloc_ptr_i(alloc_ptr_i),
    .dp0_src1_i(dp0_src1_i), .dp0_src2_i(dp0_src2_i),
    .dp0_src1_rdy_i(dp0_src1_rdy_i), .dp0_src2_rdy_i(dp0_src2_rdy_i), .dp0_ctrl_i(dp0_ctrl_i),
    .dp1_src1_i(dp1_src1_i), .dp1_src2_i(dp1_src2_i),
    .dp1_src1_rdy_i(dp1_src1_rdy_i), .dp1_src2_rdy_i(dp1_src2_rdy_i), .dp1_ctrl_i(dp1_ctrl_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .issue_ptr_i(issue_ptr_i), .issue_en_i(issue_en_i),
    .busy_vector_o(busy_vector_o), .busy_vector_next_o(busy_vector_next_o),
    .ready_vector_o(ready_vector_o), .iss_valid_o(iss_valid_o),
    .iss_src1_o(iss_src1_o), .iss_src2_o(iss_src2_o), .iss_ctrl_o(iss_ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every issue seen on the falling edge must match the oldest prediction.
  always @(negedge clk_i) begin
    if (iss_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_issue: got %h/%h/%h, expected no issue", iss_src1_o, iss_src2_o, iss_ctrl_o);
      end else begin
        iss_t e;
        e = exp_q.pop_front();
        if ({iss_src1_o, iss_src2_o, iss_ctrl_o} !== e) begin
          errors++;
          $display("FAIL sb_issue_payload: got %h/%h/%h, expected %h/%h/%h",
                   iss_src1_o, iss_src2_o, iss_ctrl_o, e.s1, e.s2, e.c);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dp_num_i = 2'd0; dp_stall_i = 1'b0; dp_kill_i = 1'b0;
    cdb_valid_i = 1'b0; issue_en_i = 1'b0;
  endtask

  task automatic set_dp(input int slot, input logic [31:0] s1, input logic r1,
                        input logic [31:0] s2, input logic r2, input logic [15:0] c);
    if (slot == 0) begin
      dp0_src1_i = s1; dp0_src1_rdy_i = r1; dp0_src2_i = s2; dp0_src2_rdy_i = r2; dp0_ctrl_i = c;
    end else begin
      dp1_src1_i = s1; dp1_src1_rdy_i = r1; dp1_src2_i = s2; dp1_src2_rdy_i = r2; dp1_ctrl_i = c;
    end
  endtask

  // Issue one entry for a single cycle and predict its payload.
  task automatic do_issue(input logic [1:0] ptr, input iss_t e);
    issue_ptr_i = ptr; issue_en_i = 1'b1;
    exp_q.push_back(e);
    last_iss = e;
    cyc();
    issue_en_i = 1'b0;
    checks++;
    if (iss_valid_o !== 1'b1) begin
      errors++; $display("FAIL issue_valid: got %b, expected 1", iss_valid_o);
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    idle();
    cyc(); cyc();
    checks++;
    if ({busy_vector_o, ready_vector_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_ctrl_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ready=%b v=%b %h/%h/%h, expected all 0",
               busy_vector_o, ready_vector_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_ctrl_o);
    end
    reset_ni = 1'b1;
    cyc();
  endtask

  task automatic test_dispatch_wrap();
    alloc_ptr_i = 2'd3; dp_num_i = 2'd2;
    set_dp(0, 32'h11, 1'b1, 32'h22, 1'b1, 16'hA0);
    set_dp(1, 32'h33, 1'b1, 32'h44, 1'b1, 16'hA1);
    #1;
    checks++;
    if (busy_vector_next_o !== 4'b1001) begin
      errors++; $display("FAIL dispatch_busy_next: got %b, expected 1001", busy_vector_next_o);
    end
    cyc(); idle();
    checks++;
    if (busy_vector_o !== 4'b1001 || ready_vector_o !== 4'b1001) begin
      errors++; $display("FAIL dispatch_wrap: got busy=%b ready=%b, expected 1001/1001", busy_vector_o, ready_vector_o);
    end
    do_issue(2'd3, {32'h11, 32'h22, 16'hA0});
    do_issue(2'd0, {32'h33, 32'h44, 16'hA1});
    cyc();
    checks++;
    if (busy_vector_o !== 4'b0000 || iss_valid_o !== 1'b0) begin
      errors++; $display("FAIL dispatch_drain: got busy=%b v=%b, expected 0000/0", busy_vector_o, iss_valid_o);
    end
  endtask

  task automatic test_wakeup();
    // entry 1: src2 waits on tag 5; entry 2: both wait on tag 7; entry 3: waits on tag 9
    alloc_ptr_i = 2'd1; dp_num_i = 2'd2;
    set_dp(0, 32'h100, 1'b1, 32'h05, 1'b0, 16'hB1);
    set_dp(1, 32'h07, 1'b0, 32'h07, 1'b0, 16'hB2);
    cyc();
    alloc_ptr_i = 2'd3; dp_num_i = 2'd1;
    set_dp(0, 32'h09, 1'b0, 32'h300, 1'b1, 16'hB3);
    cyc(); idle();
    checks++;
    if (busy_vector_o !== 4'b1110 || ready_vector_o !== 4'b0000) begin
      errors++; $display("FAIL wakeup_pre: got busy=%b ready=%b, expected 1110/0000", busy_vector_o, ready_vector_o);
    end
    cdb_valid_i = 1'b1; cdb_tag_i = 6'h05; cdb_data_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (ready_vector_o !== 4'b0000) begin
      errors++; $display("FAIL wakeup_same_cycle: got %b, expected 0000", ready_vector_o);
    end
    cyc();
    cdb_tag_i = 6'h07; cdb_data_i = 32'hCAFE0007;
    cyc();
    cdb_tag_i = 6'h08; cdb_data_i = 32'h88888888;
    cyc(); idle();
    checks++;
    if (ready_vector_o !== 4'b0110) begin
      errors++; $display("FAIL wakeup_ready: got %b, expected 0110", ready_vector_o);
    end
    do_issue(2'd1, {32'h100, 32'hDEADBEEF, 16'hB1});
    do_issue(2'd2, {32'hCAFE0007, 32'hCAFE0007, 16'hB2});
    cdb_valid_i = 1'b1; cdb_tag_i = 6'h09; cdb_data_i = 32'h99;
    cyc(); idle();
    do_issue(2'd3, {32'h99, 32'h300, 16'hB3});
  endtask

  task automatic test_bypass();
    alloc_ptr_i = 2'd2; dp_num_i = 2'd1;
    set_dp(0, 32'h0A, 1'b0, 32'h77, 1'b1, 16'hC2);
    cdb_valid_i = 1'b1; cdb_tag_i = 6'h0A; cdb_data_i = 32'h1234;
    cyc(); idle();
    checks++;
    if (ready_vector_o !== 4'b0100) begin
      errors++; $display("FAIL bypass_ready: got %b, expected 0100", ready_vector_o);
    end
    do_issue(2'd2, {32'h1234, 32'h77, 16'hC2});
  endtask

  task automatic test_issue_handshake();
    alloc_ptr_i = 2'd2; dp_num_i = 2'd1;
    set_dp(0, 32'h5555, 1'b1, 32'h6666, 1'b1, 16'hD2);
    cyc(); idle();
    alloc_ptr_i = 2'd3; dp_num_i = 2'd1;
    set_dp(0, 32'h21, 1'b0, 32'h1, 1'b1, 16'hD3);
    issue_ptr_i = 2'd2; issue_en_i = 1'b0;
    cyc(); idle();
    checks++;
    if (iss_valid_o !== 1'b0 || busy_vector_o !== 4'b1100) begin
      errors++; $display("FAIL hs_hold: got v=%b busy=%b, expected 0/1100", iss_valid_o, busy_vector_o);
    end
    // issue_en on an entry that is not ready must not fire and payload holds
    issue_ptr_i = 2'd3; issue_en_i = 1'b1;
    cyc(); idle();
    checks++;
    if (iss_valid_o !== 1'b0 || {iss_src1_o, iss_src2_o, iss_ctrl_o} !== last_iss) begin
      errors++; $display("FAIL hs_not_ready: got v=%b %h/%h/%h, expected 0 and held payload",
                         iss_valid_o, iss_src1_o, iss_src2_o, iss_ctrl_o);
    end
    do_issue(2'd2, {32'h5555, 32'h6666, 16'hD2});
    checks++;
    if (busy_vector_o !== 4'b1000) begin
      errors++; $display("FAIL hs_busy_clear: got %b, expected 1000", busy_vector_o);
    end
  endtask

  task automatic test_kill();
    alloc_ptr_i = 2'd0; dp_num_i = 2'd2;
    set_dp(0, 32'h1, 1'b1, 32'h2, 1'b1, 16'hE0);
    set_dp(1, 32'h3, 1'b1, 32'h4, 1'b1, 16'hE1);
    cyc(); idle();
    checks++;
    if (busy_vector_o !== 4'b1011) begin
      errors++; $display("FAIL kill_setup: got %b, expected 1011", busy_vector_o);
    end
    dp_kill_i = 1'b1; dp_num_i = 2'd1; alloc_ptr_i = 2'd2;
    issue_ptr_i = 2'd0; issue_en_i = 1'b1;
    #1;
    checks++;
    if (busy_vector_next_o !== 4'b0000) begin
      errors++; $display("FAIL kill_busy_next: got %b, expected 0000", busy_vector_next_o);
    end
    cyc(); idle();
    checks++;
    if (busy_vector_o !== 4'b0000 || iss_valid_o !== 1'b0 || ready_vector_o !== 4'b0000) begin
      errors++; $display("FAIL kill_state: got busy=%b v=%b ready=%b, expected 0000/0/0000",
                         busy_vector_o, iss_valid_o, ready_vector_o);
    end
  endtask

  task automatic test_stall();
    alloc_ptr_i = 2'd0; dp_num_i = 2'd1;
    set_dp(0, 32'hF0, 1'b1, 32'hF1, 1'b1, 16'hF2);
    cyc(); idle();
    dp_stall_i = 1'b1; dp_num_i = 2'd2; alloc_ptr_i = 2'd1;
    #1;
    checks++;
    if (busy_vector_next_o !== 4'b0001) begin
      errors++; $display("FAIL stall_busy_next: got %b, expected 0001", busy_vector_next_o);
    end
    cyc();
    checks++;
    if (busy_vector_o !== 4'b0001) begin
      errors++; $display("FAIL stall_busy: got %b, expected 0001", busy_vector_o);
    end
    issue_ptr_i = 2'd0; issue_en_i = 1'b1;
    #1;
    checks++;
    if (busy_vector_next_o !== 4'b0000) begin
      errors++; $display("FAIL stall_issue_next: got %b, expected 0000", busy_vector_next_o);
    end
    issue_en_i = 1'b0;
    do_issue(2'd0, {32'hF0, 32'hF1, 16'hF2});
    idle();
  endtask

  task automatic test_back_to_back();
    iss_t e [4];
    for (int i = 0; i < 4; i++) e[i] = {$urandom(), $urandom(), 16'($urandom())};
    alloc_ptr_i = 2'd0; dp_num_i = 2'd2;
    set_dp(0, e[0].s1, 1'b1, e[0].s2, 1'b1, e[0].c);
    set_dp(1, e[1].s1, 1'b1, e[1].s2, 1'b1, e[1].c);
    cyc();
    alloc_ptr_i = 2'd2;
    set_dp(0, e[2].s1, 1'b1, e[2].s2, 1'b1, e[2].c);
    set_dp(1, e[3].s1, 1'b1, e[3].s2, 1'b1, e[3].c);
    cyc(); idle();
    checks++;
    if (ready_vector_o !== 4'b1111) begin
      errors++; $display("FAIL b2b_ready: got %b, expected 1111", ready_vector_o);
    end
    for (int i = 0; i < 4; i++) do_issue(2'(i), e[i]);
    cyc();
    checks++;
    if (busy_vector_o !== 4'b0000) begin
      errors++; $display("FAIL b2b_drain: got %b, expected 0000", busy_vector_o);
    end
  endtask

  task automatic test_async_reset();
    alloc_ptr_i = 2'd1; dp_num_i = 2'd1;
    set_dp(0, 32'hAB, 1'b1, 32'hCD, 1'b1, 16'h1);
    cyc(); idle();
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if (busy_vector_o !== 4'b0000 || ready_vector_o !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got busy=%b ready=%b, expected 0000/0000", busy_vector_o, ready_vector_o);
    end
    cyc();
    reset_ni = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_dispatch_wrap();
    test_wakeup();
    test_bypass();
    test_issue_handshake();
    test_kill();
    test_stall();
    test_back_to_back();
    test_async_reset();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending issues, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
